// File: rtl/quantum_scheduler.sv
// quantum_scheduler: round-robin time-slice scheduler sequencing snapshot/update/load context switches.
// Optional macro SCHED_SWITCH_COUNT_EN enables the saturating completed-switch counter.
module quantum_scheduler #(
   parameter int NUM_PROC    = 4,
   parameter int PID_W       = 2,
   parameter int QUANTUM     = 16,
   parameter int LOAD_CYCLES = 2
) (
   input  logic                Fast_Clock,
   input  logic                Raw_Reset_I,
   input  logic                Sched_Enable,
   input  logic                Instr_Retire,
   input  logic                Halt,
   input  logic                Yield_Req,
   input  logic [NUM_PROC-1:0] Proc_Active,
   output logic                Snapshot,
   output logic                Update_PC,
   output logic                Load_Proc,
   output logic [PID_W-1:0]    Proc_ID,
   output logic                Hold_Exec,
   output logic                Switch_Done,
   output logic [7:0]          Quantum_Left,
   output logic [15:0]         Switch_Count
);
   typedef enum logic [2:0] {RUN, SELECT, SAVE, UPDATE, LOAD, DONE} state_t;
   state_t state;
   logic [PID_W-1:0] next_id, target, idx;
   logic [3:0] ld_cnt;
   logic found, halt_r, trigger;
   assign trigger = (Quantum_Left == 8'd1 && Instr_Retire && Sched_Enable) || Halt || (Yield_Req && Sched_Enable);
   // descending scan so the nearest slot after Proc_ID wins
   always_comb begin
      target = '0;
      found  = 1'b0;
      idx    = '0;
      for (int k = NUM_PROC - 1; k >= 1; k--) begin
         idx = PID_W'((int'(Proc_ID) + k) % NUM_PROC);
         if (Proc_Active[idx]) begin
            found  = 1'b1;
            target = idx;
         end
      end
   end
   always_ff @(posedge Fast_Clock) begin
      if (!Raw_Reset_I) begin
         state        <= RUN;
         Proc_ID      <= '0;
         next_id      <= '0;
         Quantum_Left <= 8'(QUANTUM);
         halt_r       <= 1'b0;
         ld_cnt       <= '0;
         Snapshot     <= 1'b0;
         Update_PC    <= 1'b0;
         Load_Proc    <= 1'b0;
         Hold_Exec    <= 1'b0;
         Switch_Done  <= 1'b0;
      end else begin
         Snapshot    <= 1'b0;
         Update_PC   <= 1'b0;
         Switch_Done <= 1'b0;
         case (state)
            RUN: begin
               if (Instr_Retire && Sched_Enable && Quantum_Left != 8'd0) Quantum_Left <= Quantum_Left - 8'd1;
               if (trigger) begin
                  state     <= SELECT;
                  Hold_Exec <= 1'b1;
                  halt_r    <= Halt;
               end
            end
            // a halted process with nowhere to go keeps the pipeline stalled until a slot wakes
            SELECT: begin
               if (found) begin
                  next_id  <= target;
                  state    <= SAVE;
                  Snapshot <= 1'b1;
               end else if (!halt_r || Proc_Active[0]) begin
                  Quantum_Left <= 8'(QUANTUM);
                  state        <= RUN;
                  Hold_Exec    <= 1'b0;
               end
            end
            SAVE: begin
               state     <= UPDATE;
               Update_PC <= 1'b1;
            end
            UPDATE: begin
               Proc_ID   <= next_id;
               state     <= LOAD;
               Load_Proc <= 1'b1;
               ld_cnt    <= 4'(LOAD_CYCLES - 1);
            end
            LOAD: begin
               if (ld_cnt == 4'd0) begin
                  Load_Proc   <= 1'b0;
                  Switch_Done <= 1'b1;
                  state       <= DONE;
               end else ld_cnt <= ld_cnt - 4'd1;
            end
            DONE: begin
               Quantum_Left <= 8'(QUANTUM);
               Hold_Exec    <= 1'b0;
               state        <= RUN;
            end
            default: state <= RUN;
         endcase
      end
   end
`ifdef SCHED_SWITCH_COUNT_EN
   logic [15:0] sw_cnt;
   always_ff @(posedge Fast_Clock) begin
      if (!Raw_Reset_I) sw_cnt <= '0;
      else if (state == DONE && sw_cnt != 16'hFFFF) sw_cnt <= sw_cnt + 16'd1;
   end
   assign Switch_Count = sw_cnt;
`else
   assign Switch_Count = '0;
`endif
endmodule

// File: tb/tb_quantum_scheduler.sv
// tb_quantum_scheduler: directed stimulus with a queue-based scoreboard for switch pulses.
module tb_quantum_scheduler;
   localparam int LC = 2;
   localparam int Q  = 16;
`ifdef SCHED_SWITCH_COUNT_EN
   localparam bit CNT = 1'b1;
`else
   localparam bit CNT = 1'b0;
`endif
   typedef struct packed {logic [3:0] p; logic [1:0] id;} ev_t;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n, en, retire, halt, yield;
   logic [3:0] act;
   logic snap, upd, load, done, hold;
   logic [1:0] pid;
   logic [7:0] ql;
   logic [15:0] sc;
   int checks = 0, passes = 0, n;
   ev_t exp_q[$];
   quantum_scheduler dut (
      .Fast_Clock(clk), .Raw_Reset_I(rst_n), .Sched_Enable(en), .Instr_Retire(retire),
      .Halt(halt), .Yield_Req(yield), .Proc_Active(act), .Snapshot(snap), .Update_PC(upd),
      .Load_Proc(load), .Proc_ID(pid), .Hold_Exec(hold), .Switch_Done(done),
      .Quantum_Left(ql), .Switch_Count(sc)
   );
   task automatic chk(input string name, input int act_v, input int exp_v);
      checks++;
      if (act_v == exp_v) passes++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act_v, exp_v, $time);
   endtask
   task automatic push_switch(input logic [1:0] a, input logic [1:0] b);
      exp_q.push_back('{4'b1000, a});
      exp_q.push_back('{4'b0100, a});
      for (int i = 0; i < LC; i++) exp_q.push_back('{4'b0010, b});
      exp_q.push_back('{4'b0001, b});
   endtask
   task automatic stim(input logic r, input logic y, input logic h);
      @(negedge clk);
      retire = r; yield = y; halt = h;
      @(negedge clk);
      retire = 1'b0; yield = 1'b0; halt = 1'b0;
   endtask
   task automatic wait_idle(output int cyc);
      cyc = 0;
      while (hold && cyc < 50) begin
         cyc++;
         @(negedge clk);
      end
   endtask
   // monitor: every pulse cycle must match the next expected event
   always @(negedge clk) begin
      if (snap | upd | load | done) begin
         if (exp_q.size() == 0) chk("unexpected_pulse", int'({snap, upd, load, done, pid}), 0);
         else chk("switch_seq", int'({snap, upd, load, done, pid}), int'(exp_q.pop_front()));
      end
   end
   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end
   initial begin
      rst_n = 1'b0; en = 1'b1; retire = 1'b0; halt = 1'b0; yield = 1'b0; act = 4'b0011;
      repeat (3) @(negedge clk);
      chk("rst_pid", int'(pid), 0);
      chk("rst_ql", int'(ql), Q);
      chk("rst_hold", int'(hold), 0);
      chk("rst_sc", int'(sc), 0);
      rst_n = 1'b1;
      repeat (15) stim(1, 0, 0);
      chk("ql_after_15", int'(ql), 1);
      push_switch(2'd0, 2'd1);
      stim(1, 0, 0);
      wait_idle(n);
      chk("expiry_hold_cycles", n, 4 + LC);
      chk("expiry_pid", int'(pid), 1);
      chk("expiry_ql", int'(ql), Q);
      act = 4'b1011;
      push_switch(2'd1, 2'd3);
      stim(0, 1, 0);
      wait_idle(n);
      chk("yield_skip_pid", int'(pid), 3);
      push_switch(2'd3, 2'd0);
      stim(0, 1, 0);
      wait_idle(n);
      chk("yield_wrap_pid", int'(pid), 0);
      chk("sc_after_3", int'(sc), CNT ? 3 : 0);
      act = 4'b0001;
      repeat (15) stim(1, 0, 0);
      chk("solo_ql_1", int'(ql), 1);
      stim(1, 0, 0);
      wait_idle(n);
      chk("solo_hold_cycles", n, 1);
      chk("solo_ql_reload", int'(ql), Q);
      chk("solo_pid", int'(pid), 0);
      en = 1'b0;
      repeat (40) stim(1, 0, 0);
      chk("frozen_ql", int'(ql), Q);
      chk("frozen_hold", int'(hold), 0);
      act = 4'b0101;
      push_switch(2'd0, 2'd2);
      stim(0, 0, 1);
      wait_idle(n);
      chk("halt_hold_cycles", n, 4 + LC);
      chk("halt_pid", int'(pid), 2);
      en = 1'b1;
      repeat (15) stim(1, 0, 0);
      push_switch(2'd2, 2'd0);
      stim(1, 1, 1);
      wait_idle(n);
      chk("combo_hold_cycles", n, 4 + LC);
      chk("combo_pid", int'(pid), 0);
      repeat (5) @(negedge clk);
      chk("sc_after_5", int'(sc), CNT ? 5 : 0);
      act = 4'b0011;
      exp_q.push_back('{4'b1000, 2'd0});
      exp_q.push_back('{4'b0100, 2'd0});
      exp_q.push_back('{4'b0010, 2'd1});
      stim(0, 1, 0);
      repeat (3) @(negedge clk);
      chk("mid_load", int'(load), 1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_load", int'(load), 0);
      chk("abort_pid", int'(pid), 0);
      chk("abort_hold", int'(hold), 0);
      chk("abort_ql", int'(ql), Q);
      chk("abort_sc", int'(sc), 0);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("post_abort_hold", int'(hold), 0);
      chk("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/quantum_scheduler.md
Name: quantum_scheduler

Overview:
- Time-slice scheduler that sits directly upstream of the exec/context manager and drives its context-switch controls: Snapshot, Update_PC, Load_Proc and Proc_ID.
- Counts retired instructions of the running process. On quantum expiry, halt or yield, it picks the next active process round-robin and sequences the save/update/load handshake.
- Holds the pipeline stalled for the whole switch.

Parameters:
NUM_PROC, 4, number of process slots; slot 0 is the OS.
PID_W, 2, width of Proc_ID; clog2(NUM_PROC).
QUANTUM, 16, instructions per time slice, range 1..255.
LOAD_CYCLES, 2, Fast_Clock cycles Load_Proc is held high, range 1..15.

Ports:
Fast_Clock  in  1  system clock; all state updates on rising edge.
Raw_Reset_I  in  1  synchronous active-low reset.
Sched_Enable  in  1  1 = preemption allowed; 0 = quantum counter frozen, no switches started.
Instr_Retire  in  1  one-cycle pulse per retired instruction of the running process.
Halt  in  1  running process executed halt; requests a switch.
Yield_Req  in  1  one-cycle software yield request.
Proc_Active  in  NUM_PROC  bit i = slot i holds a runnable process.
Snapshot  out  1  one-cycle pulse: save current context.
Update_PC  out  1  one-cycle pulse: commit saved PC.
Load_Proc  out  1  high LOAD_CYCLES cycles: restore context of Proc_ID.
Proc_ID  out  PID_W  running/target process id.
Hold_Exec  out  1  stall PC/register writes while switching.
Switch_Done  out  1  one-cycle pulse after a completed switch.
Quantum_Left  out  8  remaining instructions in current slice.
Switch_Count  out  16  completed switches (see Optional Feature).

Behaviour:
- Reset (Raw_Reset_I=0 at an edge): state RUN, Proc_ID=0, Quantum_Left=QUANTUM, Switch_Count=0, and all pulse/strobe outputs plus Hold_Exec =0. Reset mid-switch aborts immediately with no further pulses.
- States: RUN, SELECT, SAVE, UPDATE, LOAD, DONE.
- RUN, counting: Instr_Retire with Sched_Enable=1 decrements Quantum_Left. It saturates at 0 and never wraps.
- RUN, switch trigger: a switch is requested when
  - (Quantum_Left==1 and Instr_Retire and Sched_Enable), or
  - Halt, or
  - (Yield_Req and Sched_Enable).
  Halt is honoured even when Sched_Enable=0. A request moves RUN->SELECT on the next edge.
- SELECT (1 cycle): target = first set bit of Proc_Active scanning Proc_ID+1, Proc_ID+2, … modulo NUM_PROC, excluding Proc_ID itself.
  - No other bit set: reload Quantum_Left=QUANTUM, return to RUN, no switch pulses. Halt with no other process: stay in RUN on slot 0 only if bit 0 is set; otherwise hold Hold_Exec=1 in SELECT, re-evaluating each cycle until some bit sets.
  - Target found: latch it in next_id and go to SAVE.
- SAVE (1 cycle): Snapshot=1; Proc_ID still the old id.
- UPDATE (1 cycle): Update_PC=1; Proc_ID<=next_id on exit.
- LOAD (LOAD_CYCLES cycles): Load_Proc=1 with Proc_ID=new id.
- DONE (1 cycle): Switch_Done=1, Quantum_Left<=QUANTUM, Switch_Count++, then RUN.
- Hold_Exec=1 in SELECT, SAVE, UPDATE, LOAD, DONE.
- Latency: trigger edge to Snapshot = 2 cycles; full switch = 4+LOAD_CYCLES cycles.
- Inputs are ignored outside RUN: Instr_Retire, Yield_Req and Halt are not queued.
- Proc_Active changes during SAVE..DONE do not alter the latched target.
- Simultaneous Halt+Yield+expiry produce a single switch.

Optional Feature:
- Macro: SCHED_SWITCH_COUNT_EN.
- Defined: Switch_Count is a 16-bit counter incremented in DONE, saturating at 16'hFFFF, cleared by reset.
- Undefined: no counter register; Switch_Count tied to 0.

Test Plan:
- Reset, Proc_Active=4'b0011, QUANTUM=16, 16 Instr_Retire pulses -> Quantum_Left 16→1; on the 16th pulse the next edge enters SELECT. Then Snapshot, Update_PC, Load_Proc×2, Switch_Done appear in consecutive cycles; Proc_ID 0→1; Quantum_Left=16.
- Proc_ID=1, Proc_Active=4'b1011, Yield_Req -> target 3 (slot 2 skipped); then a second yield -> wraps to 0.
- Proc_Active=4'b0001, quantum expiry -> no Snapshot, Quantum_Left reloads to 16, Hold_Exec high exactly 1 cycle.
- Sched_Enable=0, 40 Instr_Retire pulses -> Quantum_Left unchanged, no switch. Then Halt with Proc_Active=4'b0101 from Proc_ID=0 -> switch to 2.
- Raw_Reset_I=0 during LOAD -> next cycle Load_Proc=0, Proc_ID=0, state RUN, Quantum_Left=16.
- With SCHED_SWITCH_COUNT_EN, 3 completed switches -> Switch_Count=3; without the macro -> Switch_Count=0.
